// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array edge feeder.
package sa_pkg;

  localparam int SA_DATA_SIZE = 32;
  localparam int SA_NUM_LANES = 4;
  localparam int SA_SLOT_OVH  = 2;
  localparam int SA_SLOT_W    = SA_DATA_SIZE + SA_SLOT_OVH;

  typedef enum logic [1:0] {SA_IDLE, SA_STREAM, SA_DRAIN} sa_feed_state_e;

  typedef struct packed {
    logic                    valid;
    logic                    last;
    logic [SA_DATA_SIZE-1:0] data;
  } sa_slot_t;

endpackage

// File: rtl/sa_delay_line.sv
// Enable-gated shift chain of DEPTH registers; o_flag_any reports whether any
// stage has bit FLAG_BIT set (used as a per-lane occupancy flag).
module sa_delay_line #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 1,
  parameter int FLAG_BIT = WIDTH - 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_flag_any
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
    end else if (i_enable) begin
      r_stage[0] <= i_d;
      for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  always_comb begin
    o_flag_any = 1'b0;
    for (int s = 0; s < DEPTH; s++) o_flag_any = o_flag_any | r_stage[s][FLAG_BIT];
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/sa_input_skewer.sv
// Diagonal skew feeder: lane i delays each accepted row by i+1 advance cycles and
// drains with bubbles after a tile's last beat so tiles never overlap on the diagonal.
module sa_input_skewer
  import sa_pkg::*;
#(
  parameter int DATA_SIZE = SA_DATA_SIZE,
  parameter int NUM_LANES = SA_NUM_LANES
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_enable,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic                           i_in_last,
  input  logic [NUM_LANES*DATA_SIZE-1:0] i_in_data,
  output logic [NUM_LANES-1:0]           o_out_valid,
  output logic [NUM_LANES*DATA_SIZE-1:0] o_out_data,
  output logic                           o_out_last,
  output logic                           o_busy
);

  localparam int SLOT_W = DATA_SIZE + SA_SLOT_OVH;
  localparam int CNT_W  = $clog2(NUM_LANES) + 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(NUM_LANES - 1);

  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic [DATA_SIZE-1:0] data;
  } slot_t;

  sa_feed_state_e         r_state;
  logic [CNT_W-1:0]       r_drain_cnt;
  logic                   w_accept;
  logic                   w_tail_last;
  logic [NUM_LANES-1:0]   w_lane_busy;

  assign o_in_ready = i_enable && (r_state != SA_DRAIN);
  assign w_accept   = i_in_valid && o_in_ready;

  // IDLE: no tile open | STREAM: tile open, gaps allowed | DRAIN: bubbles until last beat clears
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= SA_IDLE;
      r_drain_cnt <= '0;
    end else if (i_enable) begin
      case (r_state)
        SA_IDLE, SA_STREAM: begin
          if (w_accept) begin
            if (!i_in_last) begin
              r_state <= SA_STREAM;
            end else if (NUM_LANES == 1) begin
              r_state <= SA_IDLE;
            end else begin
              r_state     <= SA_DRAIN;
              r_drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        SA_DRAIN: begin
          if (r_drain_cnt <= CNT_W'(1)) begin
            r_state     <= SA_IDLE;
            r_drain_cnt <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state     <= SA_IDLE;
          r_drain_cnt <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    slot_t w_in_slot;
    slot_t w_out_slot;
    logic  w_occupied;

    always_comb begin
      w_in_slot = '0;
      if (w_accept) begin
        w_in_slot.valid = 1'b1;
        w_in_slot.last  = i_in_last;
        w_in_slot.data  = i_in_data[g*DATA_SIZE +: DATA_SIZE];
      end
    end

    sa_delay_line #(
      .WIDTH    (SLOT_W),
      .DEPTH    (g + 1),
      .FLAG_BIT (SLOT_W - 1)
    ) u_delay (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_enable   (i_enable),
      .i_d        (w_in_slot),
      .o_q        (w_out_slot),
      .o_flag_any (w_occupied)
    );

    assign w_lane_busy[g]                          = w_occupied;
    assign o_out_valid[g]                          = w_out_slot.valid;
    assign o_out_data[g*DATA_SIZE +: DATA_SIZE]    = w_out_slot.data;

    // Only the longest lane reports the tile boundary.
    if (g == NUM_LANES - 1) begin : g_tail
      assign w_tail_last = w_out_slot.valid & w_out_slot.last;
    end else begin : g_body
      logic w_unused_last;
      assign w_unused_last = w_out_slot.last;
    end
  end

  assign o_out_last = w_tail_last;
  assign o_busy     = (|w_lane_busy) || (r_state != SA_IDLE);

endmodule

// File: tb/tb_sa_input_skewer.sv
// Directed bench for sa_input_skewer: a row-history model predicts every lane each cycle,
// plus literal checks on skew, stall, gap, back-to-back and single-lane behaviour.
module tb_sa_input_skewer;
  localparam int DW = 32;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic vld = 1'b0;
  logic lst = 1'b0;
  logic [NL*DW-1:0] dat = '0;
  logic rdy, olast, obusy;
  logic [NL-1:0] ovld;
  logic [NL*DW-1:0] odat;

  logic vld1 = 1'b0;
  logic lst1 = 1'b0;
  logic [DW-1:0] dat1 = '0;
  logic rdy1, olast1, obusy1;
  logic [0:0] ovld1;
  logic [DW-1:0] odat1;

  int n_tests = 0;
  int n_fail = 0;
  int olast_cnt = 0;
  int l3_cnt = 0;

  always #5 clk = ~clk;

  sa_input_skewer #(.DATA_SIZE(DW), .NUM_LANES(NL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_in_valid(vld), .o_in_ready(rdy),
    .i_in_last(lst), .i_in_data(dat), .o_out_valid(ovld), .o_out_data(odat),
    .o_out_last(olast), .o_busy(obusy));

  sa_input_skewer #(.DATA_SIZE(DW), .NUM_LANES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_in_valid(vld1), .o_in_ready(rdy1),
    .i_in_last(lst1), .i_in_data(dat1), .o_out_valid(ovld1), .o_out_data(odat1),
    .o_out_last(olast1), .o_busy(obusy1));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: history of what was injected at each advance; lane i shows injection n-i.
  logic hv [0:1023];
  logic hl [0:1023];
  logic [NL*DW-1:0] hd [0:1023];
  int n_adv = 0;
  int drain_left = 0;
  bit in_tile = 1'b0;
  bit m_acc;

  task automatic model_clear();
    for (int k = 0; k < 1024; k++) begin
      hv[k] = 1'b0; hl[k] = 1'b0; hd[k] = '0;
    end
    n_adv = 0; drain_left = 0; in_tile = 1'b0;
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n && en && n_adv < 1023) begin
      m_acc = vld && (drain_left == 0);
      n_adv++;
      hv[n_adv] = m_acc;
      hl[n_adv] = m_acc && lst;
      hd[n_adv] = m_acc ? dat : '0;
      if (m_acc && lst) begin
        in_tile = 1'b0;
        drain_left = NL - 1;
      end else begin
        if (m_acc) in_tile = 1'b1;
        if (drain_left > 0) drain_left--;
      end
    end
  end

  always @(negedge clk) begin
    automatic logic [NL-1:0] ev = '0;
    automatic logic [NL*DW-1:0] ed = '0;
    automatic logic el = 1'b0;
    automatic logic eb;
    automatic logic any = 1'b0;
    automatic int k;
    for (int i = 0; i < NL; i++) begin
      k = n_adv - i;
      if (k >= 1 && hv[k]) begin
        ev[i] = 1'b1;
        ed[i*DW +: DW] = hd[k][i*DW +: DW];
        any = 1'b1;
      end
    end
    k = n_adv - (NL - 1);
    if (k >= 1) el = hv[k] && hl[k];
    eb = in_tile || (drain_left > 0) || any;
    chk("cyc_valid", ovld, ev);
    chk("cyc_data", odat, ed);
    chk("cyc_last", olast, el);
    chk("cyc_busy", obusy, eb);
    chk("cyc_ready", rdy, en && (drain_left == 0));
    if (olast) olast_cnt++;
    if (ovld[NL-1]) l3_cnt++;
  end

  function automatic logic [NL*DW-1:0] row(input int r);
    logic [NL*DW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = DW'(10*r + i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tile_run(input int stall_len, input string tag);
    int e;
    int low;
    e = 0;
    low = 0;
    for (int r = 0; r < 4; r++) begin
      vld = 1'b1; dat = row(r); lst = (r == 3);
      tick(); e++;
      chk({tag, "_skew_valid"}, ovld, (1 << (r + 1)) - 1);
      chk({tag, "_skew_data"}, odat[r*DW +: DW], r);
      if (r == 1 && stall_len > 0) begin
        en = 1'b0; vld = 1'b1; dat = row(2); lst = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          chk({tag, "_stall_ready"}, rdy, 0);
          chk({tag, "_stall_valid"}, ovld, 4'b0011);
          chk({tag, "_stall_data"}, odat, {32'd0, 32'd0, 32'd1, 32'd10});
          tick(); e++;
        end
        en = 1'b1;
      end
    end
    vld = 1'b0; lst = 1'b0; dat = '0;
    chk({tag, "_drain_ready"}, rdy, 0);
    low = 1;
    for (int g = 0; g < 20 && !olast; g++) begin
      tick(); e++;
      if (!rdy) low++;
    end
    chk({tag, "_last_cycle"}, e, 7 + stall_len);
    chk({tag, "_last_data"}, odat[3*DW +: DW], 33);
    chk({tag, "_ready_low"}, low, 3);
    tick(); tick();
    chk({tag, "_idle_busy"}, obusy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    model_clear();
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", rdy, 1);
    chk("rst_busy", obusy, 0);
    chk("rst_valid", ovld, 0);

    // Reset in the middle of a tile
    vld = 1'b1; dat = row(5); lst = 1'b0;
    tick(); tick();
    chk("mid_busy", obusy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ovld, 0);
    chk("mid_rst_data", odat, 0);
    chk("mid_rst_last", olast, 0);
    chk("mid_rst_busy", obusy, 0);
    tick();
    chk("mid_rst_ready", rdy, 1);
    rst_n = 1'b1; vld = 1'b0; dat = '0;
    repeat (8) tick();

    tile_run(0, "skew");
    tile_run(5, "stall");

    // Gaps: valid pattern 1,0,1,1(last); data during the gap must not leak
    olast_cnt = 0; l3_cnt = 0;
    vld = 1'b1; dat = row(0); lst = 1'b0;
    tick();
    vld = 1'b0; dat = row(9);
    tick();
    chk("gap_valid", ovld, 4'b0010);
    chk("gap_data0", odat[DW-1:0], 0);
    vld = 1'b1; dat = row(1);
    tick();
    chk("gap_valid2", ovld, 4'b0101);
    dat = row(2); lst = 1'b1;
    tick();
    vld = 1'b0; lst = 1'b0; dat = '0;
    repeat (8) tick();
    chk("gap_lane3_beats", l3_cnt, 3);
    chk("gap_lasts", olast_cnt, 1);

    // Back-to-back 2-beat tiles with in_valid held high
    olast_cnt = 0; low = 0;
    vld = 1'b1;
    for (int b = 0; b < 4; b++) begin
      dat = row(b + 1); lst = (b % 2 == 1);
      for (int g = 0; g < 20 && !rdy; g++) begin
        tick();
        if (b == 2) low++;
      end
      tick();
    end
    vld = 1'b0; lst = 1'b0; dat = '0;
    repeat (10) tick();
    chk("b2b_gap", low, NL - 1);
    chk("b2b_lasts", olast_cnt, 2);
    chk("b2b_idle", obusy, 0);

    // Single-lane instance: no drain phase
    vld1 = 1'b1; lst1 = 1'b1; dat1 = 32'd77;
    #1;
    chk("one_ready_pre", rdy1, 1);
    tick();
    vld1 = 1'b0; lst1 = 1'b0; dat1 = '0;
    chk("one_valid", ovld1, 1);
    chk("one_data", odat1, 77);
    chk("one_last", olast1, 1);
    chk("one_ready_post", rdy1, 1);
    tick();
    chk("one_valid_after", ovld1, 0);
    chk("one_busy_after", obusy1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
